jtag_host_controller: RTL

//  JTAG initiator: drives TCK/TMS/TDI and samples TDO of one ExperiarCore JTAG TAP, so on-chip management logic can debug a core.

---
 rtl/jtag_host_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/jtag_host_controller.sv
// JTAG initiator: runs one TAP-reset / IR-scan / DR-scan / idle-clock command at a time
// on a divided TCK, parks the TAP in Run-Test/Idle and returns the captured TDO bits.
module jtag_host_controller #(
    parameter int CLOCK_DIVIDE = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_type_i,
    input  logic [4:0]  cmd_length_i,
    input  logic [31:0] cmd_data_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        busy_o,
    output logic        jtag_tck_o,
    output logic        jtag_tms_o,
    output logic        jtag_tdi_o,
    input  logic        jtag_tdo_i
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_RESET, ST_SELECT, ST_IDLE_RUN, ST_SHIFT, ST_EXIT, ST_RESP
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLOCK_DIVIDE - 1);
    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_IDLE  = 2'd3;

    state_t      state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [5:0]  bit_reg, bit_next;
    logic        tck_reg, tck_next;
    logic        tms_reg, tms_next;
    logic        tdi_reg, tdi_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [1:0]  type_reg, type_next;
    logic [4:0]  len_reg, len_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] capture_reg, capture_next;
    logic        accept, phase_end, start_bit;
    logic [5:0]  last_bit;

    assign cmd_ready_o  = (state_reg == ST_IDLE) && !resp_valid_reg;
    assign busy_o       = !cmd_ready_o;
    assign accept       = cmd_ready_o && cmd_valid_i;
    assign phase_end    = (div_reg == DIV_LAST);
    assign resp_valid_o = resp_valid_reg;
    assign resp_data_o  = capture_reg;
    assign jtag_tck_o   = tck_reg;
    assign jtag_tms_o   = tms_reg;
    assign jtag_tdi_o   = tdi_reg;

    // Index of the final TCK spent in the current state.
    always_comb begin
        last_bit = 6'd0;
        case (state_reg)
            ST_RESET:    last_bit = 6'd5;
            ST_SELECT:   last_bit = (type_reg == CMD_IR) ? 6'd3 : 6'd2;
            ST_SHIFT,
            ST_IDLE_RUN: last_bit = {1'b0, len_reg};
            ST_EXIT:     last_bit = 6'd1;
            default:     last_bit = 6'd0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        div_next        = div_reg;
        bit_next        = bit_reg;
        tck_next        = tck_reg;
        tms_next        = tms_reg;
        tdi_next        = tdi_reg;
        resp_valid_next = 1'b0;
        type_next       = type_reg;
        len_next        = len_reg;
        data_next       = data_reg;
        capture_next    = capture_reg;
        start_bit       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    type_next    = cmd_type_i;
                    len_next     = cmd_length_i;
                    data_next    = cmd_data_i;
                    capture_next = 32'd0;
                    div_next     = 8'd0;
                    bit_next     = 6'd0;
                    tck_next     = 1'b0;
                    start_bit    = 1'b1;
                    case (cmd_type_i)
                        CMD_RESET: state_next = ST_RESET;
                        CMD_IDLE:  state_next = ST_IDLE_RUN;
                        default:   state_next = ST_SELECT;
                    endcase
                end
            end
            ST_RESP: begin
                state_next      = ST_IDLE;
                resp_valid_next = 1'b1;
            end
            default: begin
                if (!phase_end) begin
                    div_next = div_reg + 8'd1;
                end else begin
                    div_next = 8'd0;
                    if (!tck_reg) begin
                        tck_next = 1'b1;
                    end else begin
                        // Falling TCK: TDO is sampled before the target can update it.
                        tck_next  = 1'b0;
                        start_bit = 1'b1;
                        if (state_reg == ST_SHIFT)
                            capture_next[bit_reg[4:0]] = jtag_tdo_i;
                        if (bit_reg == last_bit) begin
                            bit_next = 6'd0;
                            case (state_reg)
                                ST_SELECT: state_next = ST_SHIFT;
                                ST_SHIFT:  state_next = ST_EXIT;
                                default:   state_next = ST_RESP;
                            endcase
                        end else begin
                            bit_next = bit_reg + 6'd1;
                        end
                    end
                end
            end
        endcase

        // TMS/TDI for the TCK whose low phase begins now.
        if (start_bit) begin
            tdi_next = 1'b0;
            case (state_next)
                ST_RESET:  tms_next = (bit_next < 6'd5);
                ST_SELECT: tms_next = (type_next == CMD_IR) ? (bit_next < 6'd2) : (bit_next == 6'd0);
                ST_SHIFT: begin
                    tms_next = (bit_next == {1'b0, len_next});
                    tdi_next = data_next[bit_next[4:0]];
                end
                ST_EXIT:   tms_next = (bit_next == 6'd0);
                default:   tms_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= ST_IDLE;
            div_reg        <= 8'd0;
            bit_reg        <= 6'd0;
            tck_reg        <= 1'b0;
            tms_reg        <= 1'b1;
            tdi_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
            type_reg       <= 2'd0;
            len_reg        <= 5'd0;
            data_reg       <= 32'd0;
            capture_reg    <= 32'd0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            bit_reg        <= bit_next;
            tck_reg        <= tck_next;
            tms_reg        <= tms_next;
            tdi_reg        <= tdi_next;
            resp_valid_reg <= resp_valid_next;
            type_reg       <= type_next;
            len_reg        <= len_next;
            data_reg       <= data_next;
            capture_reg    <= capture_next;
        end
    end
endmodule
